cdr_dlf_pi: RTL
===============

# cdr_dlf_pi

Parametrised second-order digital loop filter for the CDR, placed between the bang-bang phase detector and the phase-interpolator code input. It majority-votes UP/DN over a decimation window and updates a saturating frequency integrator and a wrapping phase integrator. Proportional gain switches from acquisition to tracking under control of a built-in lock detector. It publishes the phase code, the frequency word, an update strobe and a lock flag.

## Interface
- PHASE_W, 16: phase accumulator width; wraps modulo 2^PHASE_W.
- CODE_W, 11: output code width, taken from the top of the phase accumulator; CODE_W <= PHASE_W.
- FREQ_W, 12: signed frequency integrator width.
- DECIM, 4: PD samples per update window; range 1..64.
- KP_ACQ_SH, 6: proportional step is 1<<KP_ACQ_SH while acquiring.
- KP_TRK_SH, 4: proportional step is 1<<KP_TRK_SH while tracking.
- KI_SH, 2: integral step is 1<<KI_SH.
- FREQ_SH, 2: phase accumulator adds freq>>>FREQ_SH (arithmetic shift) per window.
- LOCK_CNT, 32: update windows per lock-detect evaluation.
- LOCK_THR, 4: lock threshold on the net direction count.
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high; clears all state.
- en, input, 1: sample enable; when low, nothing advances.
- up, input, 1: PD late indication.
- dn, input, 1: PD early indication.
- freq_hold, input, 1: freezes the frequency integrator.
- code, output, CODE_W: phase[PHASE_W-1 -: CODE_W], registered.
- freq_word, output, FREQ_W: signed frequency integrator value.
- update, output, 1: one-cycle pulse marking the first cycle in which a new code is visible.
- locked, output, 1: high in the TRK state.

## Operation
- Per-sample vote, sampled when en=1:
  - up&!dn counts +1.
  - dn&!up counts -1.
  - up==dn counts 0.
- The window counter runs 0..DECIM-1. The signed vote sum is sized for ±DECIM. The window closes on the edge where the counter is DECIM-1 and en=1.
- dir is the sign of (sum plus the current vote): +1, -1 or 0. A tie gives dir=0. On close, the sum and counter clear.
- On every window close, including dir=0:
  - freq <= sat(freq + dir*(1<<KI_SH)), clamped to [-(2^(FREQ_W-1)), 2^(FREQ_W-1)-1]. It never wraps. It is unchanged while freq_hold=1.
  - phase <= phase + dir*(1<<KP_SH) + sext(freq_old>>>FREQ_SH), modulo 2^PHASE_W (intended wrap). freq_old is the pre-update value.
  - KP_SH is KP_ACQ_SH in ACQ and KP_TRK_SH in TRK.
- Lock detector FSM, states ACQ (reset) and TRK:
  - A signed net counter sums dir over LOCK_CNT windows. It clears at the end of each evaluation.
  - ACQ->TRK when |net| <= LOCK_THR at evaluation end.
  - TRK->ACQ when |net| > 2*LOCK_THR at evaluation end.
  - Otherwise the state holds.
  - The new state and gain apply from the next window.
- When en=0: counters, integrators and FSM hold, and update stays 0.

## Timing
- Reset values: code=0, freq_word=0, update=0, locked=0. All counters are 0 and the state is ACQ.
- Latency: the closing edge registers phase, freq, code and update together. update=1 for exactly that following cycle.
- First update after reset with en held high: DECIM cycles.
- The locked change is registered on the same edge as the update that ends the evaluation.
- Reset asserted mid-window discards the partial vote and lock counts immediately (asynchronous).
- freq_hold changing mid-window takes effect at the next close.

## Configuration
- CDR_DLF_FREQ_PATH_EN defined: the full second-order loop as described.
- CDR_DLF_FREQ_PATH_EN undefined:
  - The frequency integrator is not built and freq_word is tied to 0.
  - freq_hold is ignored.
  - phase <= phase + dir*(1<<KP_SH), giving a first-order loop.
  - The lock detector and gear shift are unchanged.

## Test plan
- Reset: assert rst mid-window with votes pending -> code=0, freq_word=0, update=0, locked=0. The next full window starts from count 0.
- Constant up=1, dn=0, en=1, defaults:
  - First update at cycle 4: phase=64, code=2, freq=4.
  - Second update: phase=129, code=4, freq=8.
- Ties: up=dn=1 throughout, or 2 up + 2 dn votes per window -> update pulses every 4 cycles, code and freq_word stay unchanged.
- Saturation and wrap: constant up for 600 windows -> freq_word sticks at 2047 and never goes negative. phase wraps through 0 and code rolls from 2047 to low values.
- Lock:
  - Alternate all-up and all-down windows for 32 windows -> locked=1 at the 32nd update, and the proportional step becomes 16.
  - Then 32 all-up windows -> locked=0.
- freq_hold=1 with constant up -> freq_word frozen; phase still steps by 64 plus (frozen freq)>>>2 per window. With the macro undefined, freq_word stays 0.

Source files
------------

// File: rtl/cdr_dlf_pi.sv
// CDR second-order loop filter: majority-voted bang-bang PD, integrators and lock-controlled gear shift.
// Optional frequency path: define CDR_DLF_FREQ_PATH_EN to build the frequency integrator.
module cdr_dlf_pi #(
    parameter int PHASE_W   = 16,
    parameter int CODE_W    = 11,
    parameter int FREQ_W    = 12,
    parameter int DECIM     = 4,
    parameter int KP_ACQ_SH = 6,
    parameter int KP_TRK_SH = 4,
    parameter int KI_SH     = 2,
    parameter int FREQ_SH   = 2,
    parameter int LOCK_CNT  = 32,
    parameter int LOCK_THR  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     up,
    input  logic                     dn,
    input  logic                     freq_hold,
    output logic [CODE_W-1:0]        code,
    output logic signed [FREQ_W-1:0] freq_word,
    output logic                     update,
    output logic                     locked
);
    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int SUM_W = $clog2(DECIM + 1) + 1;
    localparam int LC_W  = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int NET_W = $clog2(LOCK_CNT + 1) + 1;

    typedef enum logic {ACQ, TRK} state_t;
    state_t state, state_next;

    logic [CNT_W-1:0]        win_cnt;
    logic signed [SUM_W-1:0] vote_sum, vote, vote_total;
    logic [LC_W-1:0]         lock_cnt;
    logic signed [NET_W-1:0] net, net_total;
    logic [NET_W-1:0]        net_abs;
    logic [PHASE_W-1:0]      phase, phase_next, kp_step;
    logic                    close, eval_end, dir_pos, dir_neg;

    always_comb begin
        vote = '0;
        if (up && !dn)
            vote = SUM_W'(1);
        else if (dn && !up)
            vote = '1;
    end

    assign close      = en && (win_cnt == CNT_W'(DECIM - 1));
    assign vote_total = vote_sum + vote;
    assign dir_neg    = vote_total[SUM_W-1];
    assign dir_pos    = !vote_total[SUM_W-1] && (vote_total != '0);

    assign kp_step = (state == TRK) ? (PHASE_W'(1) << KP_TRK_SH) : (PHASE_W'(1) << KP_ACQ_SH);

`ifdef CDR_DLF_FREQ_PATH_EN
    logic signed [FREQ_W:0]   freq_sum;
    logic signed [FREQ_W-1:0] freq_sat, freq_shr;
    logic [PHASE_W-1:0]       freq_ext;

    // One guard bit; saturate when it disagrees with the result sign.
    always_comb begin
        freq_sum = {freq_word[FREQ_W-1], freq_word};
        if (dir_pos)
            freq_sum = freq_sum + ((FREQ_W + 1)'(1) << KI_SH);
        else if (dir_neg)
            freq_sum = freq_sum - ((FREQ_W + 1)'(1) << KI_SH);
        if (freq_sum[FREQ_W] != freq_sum[FREQ_W-1])
            freq_sat = freq_sum[FREQ_W] ? {1'b1, {(FREQ_W-1){1'b0}}} : {1'b0, {(FREQ_W-1){1'b1}}};
        else
            freq_sat = freq_sum[FREQ_W-1:0];
    end

    assign freq_shr = freq_word >>> FREQ_SH;
    assign freq_ext = PHASE_W'(freq_shr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            freq_word <= '0;
        else if (close && !freq_hold)
            freq_word <= freq_sat;
    end
`else
    logic unused_freq_hold;
    assign unused_freq_hold = freq_hold;
    assign freq_word        = '0;
`endif

    always_comb begin
        phase_next = phase;
        if (dir_pos)
            phase_next = phase + kp_step;
        else if (dir_neg)
            phase_next = phase - kp_step;
`ifdef CDR_DLF_FREQ_PATH_EN
        phase_next = phase_next + freq_ext;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt  <= '0;
            vote_sum <= '0;
            phase    <= '0;
            update   <= 1'b0;
        end else begin
            update <= close;
            if (close) begin
                win_cnt  <= '0;
                vote_sum <= '0;
                phase    <= phase_next;
            end else if (en) begin
                win_cnt  <= win_cnt + CNT_W'(1);
                vote_sum <= vote_total;
            end
        end
    end

    assign code = phase[PHASE_W-1 -: CODE_W];

    // Lock detector: net window direction over LOCK_CNT windows.
    assign eval_end = close && (lock_cnt == LC_W'(LOCK_CNT - 1));

    always_comb begin
        net_total = net;
        if (dir_pos)
            net_total = net + NET_W'(1);
        else if (dir_neg)
            net_total = net - NET_W'(1);
        net_abs = net_total[NET_W-1] ? NET_W'(-net_total) : NET_W'(net_total);
    end

    always_comb begin
        state_next = state;
        if (eval_end) begin
            case (state)
                ACQ: if (int'(net_abs) <= LOCK_THR) state_next = TRK;
                TRK: if (int'(net_abs) > 2 * LOCK_THR) state_next = ACQ;
                default: state_next = ACQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ACQ;
            lock_cnt <= '0;
            net      <= '0;
        end else begin
            state <= state_next;
            if (eval_end) begin
                lock_cnt <= '0;
                net      <= '0;
            end else if (close) begin
                lock_cnt <= lock_cnt + LC_W'(1);
                net      <= net_total;
            end
        end
    end

    assign locked = (state == TRK);

endmodule
